// File: rtl/cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_issuer
// Description : FIFO-buffered command front-end that issues single-cycle ce
//               pulses to the ALU CPU core. It inserts OP_GAP idle cycles
//               after each operation command.
//               Optional statistics counters: define CMD_ISSUER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_issuer #(
  parameter int DEPTH  = 8,
  parameter int OP_GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_data,
  input  logic [7:0]                cmd_opcode,
  input  logic                      cmd_load,
  input  logic                      cmd_cin,
  input  logic                      cmd_cout,
  input  logic                      hold,
  output logic [7:0]                data_in,
  output logic [7:0]                opcode,
  output logic                      cin,
  output logic                      cout,
  output logic                      load,
  output logic                      ce,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      busy
`ifdef CMD_ISSUER_STATS_EN
  ,
  output logic [15:0]               issue_count,
  output logic [15:0]               op_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (OP_GAP < 1) ? 1 : $clog2(OP_GAP + 1);
  localparam int EW = 19;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [GW-1:0] GAP_ONE = 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GAP  = 1'b1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [0:0]    r_state;
  logic [GW-1:0] r_gap;

  logic [7:0]    r_data;
  logic [7:0]    r_opcode;
  logic          r_cin;
  logic          r_cout;
  logic          r_load;
  logic          r_ce;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Equal index with differing wrap bit means the FIFO is full
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !hold;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {cmd_load, cmd_cout, cmd_cin, cmd_opcode, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= S_IDLE;
      r_gap    <= '0;
      r_data   <= '0;
      r_opcode <= '0;
      r_cin    <= 1'b0;
      r_cout   <= 1'b0;
      r_load   <= 1'b0;
      r_ce     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_ce <= w_pop;
      if (w_pop) begin
        {r_load, r_cout, r_cin, r_opcode, r_data} <= w_head;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop && !w_head[EW-1] && (OP_GAP != 0)) begin
            r_state <= S_GAP;
            r_gap   <= GW'(OP_GAP);
          end
        end
        S_GAP: begin
          r_gap <= r_gap - GAP_ONE;
          if (r_gap == GAP_ONE) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CMD_ISSUER_STATS_EN
  logic [15:0] r_issue_count;
  logic [15:0] r_op_count;

  // Counted at the pop edge so the value moves together with ce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_count <= '0;
      r_op_count    <= '0;
    end else if (w_pop) begin
      r_issue_count <= r_issue_count + 16'd1;
      if (!w_head[EW-1]) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign issue_count = r_issue_count;
  assign op_count    = r_op_count;
`endif

  assign cmd_ready  = !w_full;
  assign data_in    = r_data;
  assign opcode     = r_opcode;
  assign cin        = r_cin;
  assign cout       = r_cout;
  assign load       = r_load;
  assign ce         = r_ce;
  assign fifo_level = r_wr_ptr - r_rd_ptr;
  assign busy       = !w_empty || (r_state != S_IDLE) || r_ce;

endmodule
`default_nettype wire

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
- Upstream command front-end for the 8-register ALU CPU core.
- Accepts load and operation commands over a valid/ready handshake and buffers them in a FIFO.
- Drives the core's data_in, opcode, cin, cout, load and ce inputs as single-cycle ce pulses.
- Spaces operation commands so that no ce pulse lands while the core is in its OPERATION or WAIT state.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- OP_GAP, 2, idle cycles forced after an operation issue; matches the core's OPERATION+WAIT residency.
- Localparam AW = clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_data  in  8  operand byte
- cmd_opcode  in  8  [6:4] register select, [3:0] ALU operation
- cmd_load  in  1  1 = register load, 0 = ALU operation
- cmd_cin  in  1  carry-in for operation
- cmd_cout  in  1  cout control bit for operation
- hold  in  1  pauses new issues
- data_in  out  8  to core
- opcode  out  8  to core
- cin  out  1  to core
- cout  out  1  to core
- load  out  1  to core
- ce  out  1  one-cycle issue strobe to core
- fifo_level  out  AW+1  current occupancy, 0..DEPTH
- busy  out  1  FIFO non-empty OR state != S_IDLE OR ce

Behaviour:
- Reset, sampled on the clk edge:
  - FIFO flushed; rd/wr pointers = 0.
  - State = S_IDLE; gap counter = 0.
  - All core-side outputs (data_in, opcode, cin, cout, load, ce) = 0.
  - fifo_level = 0, busy = 0, cmd_ready = 1 in the first cycle after reset.
  - Reset mid-gap or with a full FIFO discards everything; no ce pulse follows.
- Push:
  - Occurs when cmd_valid && cmd_ready at the clk edge.
  - Entry = {cmd_load, cmd_cout, cmd_cin, cmd_opcode, cmd_data}, 19 bits.
  - cmd_ready depends only on full. A push is refused on full even if a pop occurs in the same cycle.
- Pop/issue:
  - Occurs in S_IDLE when FIFO non-empty and hold == 0.
  - The head entry is registered onto the core outputs and ce = 1 in the next cycle.
  - ce is high for exactly one cycle per command. The outputs hold their last values while ce = 0.
- No fall-through: an entry pushed into an empty FIFO is poppable the following cycle.
  - Minimum latency is 2 cycles: handshake edge at cycle A, ce high in cycle A+2.
- Simultaneous push and pop on a non-full FIFO: both happen and the level is unchanged.
- Pointers wrap modulo DEPTH; full/empty are distinguished by the extra pointer bit.
- State machine:
  - S_IDLE: issue as above.
    - If the popped entry has load = 1, stay in S_IDLE; back-to-back loads give ce high every cycle.
    - If load = 0, go to S_GAP with gap counter = OP_GAP.
  - S_GAP: no pop, ce = 0. The counter decrements each cycle; on the cycle the counter is 1, return to S_IDLE.
    - Operation ce at cycle T gives the next possible ce at T+1+OP_GAP (T+3 by default).
  - OP_GAP = 0 means S_GAP is never entered.
- hold:
  - Sampled only in S_IDLE. hold = 1 blocks the pop.
  - It does not truncate or extend an active gap, and it does not block pushes.

Optional Feature:
- Macro: CMD_ISSUER_STATS_EN.
- Defined:
  - Adds outputs issue_count (16 bits) and op_count (16 bits).
  - issue_count increments on every ce pulse; op_count increments on ce pulses with load = 0.
  - Both wrap 0xFFFF→0x0000 and clear on rst.
- Not defined: the ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then push load {data 0x5A, opcode 0x30} at cycle A → ce high only in A+2 with data_in = 0x5A, opcode = 0x30, load = 1; fifo_level returns to 0.
- Push 3 loads then 1 op (opcode 0x12, cin = 1) then 1 load → ce in 4 consecutive cycles T..T+3 (op at T+3), ce low T+4..T+5, final load ce at T+6.
- hold = 1, push DEPTH=8 commands → cmd_ready = 0, fifo_level = 8, ce never high, 9th cmd_valid not accepted. Release hold → 8 ce pulses issued in FIFO order.
- Full FIFO, hold = 0 → in the pop cycle cmd_ready is still 0 and the push is refused; next cycle cmd_ready = 1 and fifo_level = 7.
- Assert rst in the cycle after an operation ce with 4 entries queued → next cycle fifo_level = 0, ce = 0, busy = 0, and no ce for 10 cycles.
- With CMD_ISSUER_STATS_EN: issue 5 loads and 2 ops → issue_count = 7, op_count = 2. Preload counters near wrap via 65536 issues → wraps to 0.
